// File: rtl/connect4_pkg.sv
// Shared types and constants for the random move selector.
// The optional seed-load feature is controlled by the RMS_SEED_LOAD_EN macro.
package connect4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } rms_state_t;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;
  localparam int          DEFAULT_ROWS      = 6;
  localparam int          DEFAULT_COLS      = 7;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that free-runs out of reset, with an optional seed load.
// A zero seed (parameter or loaded value) is replaced by 1 so the LFSR never locks up.
module lfsr16
  import connect4_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  localparam logic [15:0] SEED_FIX = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] value_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      value_reg <= SEED_FIX;
    end else if (load) begin
      value_reg <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else begin
      value_reg <= lfsr_step(value_reg);
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/random_move_selector.sv
// Picks a non-full column (random or column-0 start) and its landing row.
// Scans one column per cycle; RMS_SEED_LOAD_EN adds seed_we/seed_in to reseed the LFSR.
module random_move_selector
  import connect4_pkg::*;
#(
  parameter int          ROWS      = DEFAULT_ROWS,
  parameter int          COLS      = DEFAULT_COLS,
  parameter logic [15:0] LFSR_SEED = DEFAULT_LFSR_SEED
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic [ROWS-1:0][COLS-1:0]    board_in,
`ifdef RMS_SEED_LOAD_EN
  input  logic                         seed_we,
  input  logic [15:0]                  seed_in,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         no_move,
  output logic [$clog2(COLS)-1:0]      col_out,
  output logic [$clog2(ROWS)-1:0]      row_out
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic [15:0] lfsr_value;
  logic        seed_load;
  logic [15:0] seed_val;

`ifdef RMS_SEED_LOAD_EN
  assign seed_load = seed_we;
  assign seed_val  = seed_in;
`else
  assign seed_load = 1'b0;
  assign seed_val  = 16'h0000;
`endif

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (seed_load),
    .seed  (seed_val),
    .value (lfsr_value)
  );

  rms_state_t                   state_reg;
  logic [ROWS-1:0][COLS-1:0]    board_reg;
  logic [COL_W-1:0]             cur_col_reg;
  logic [COL_W-1:0]             probe_cnt_reg;
  logic [COL_W-1:0]             res_col_reg;
  logic [ROW_W-1:0]             res_row_reg;
  logic                         res_none_reg;
  logic                         busy_reg;
  logic                         done_reg;
  logic                         no_move_reg;
  logic [COL_W-1:0]             col_out_reg;
  logic [ROW_W-1:0]             row_out_reg;

  // Column-major view of the captured board, plus per-column full flag and landing row.
  logic [COLS-1:0][ROWS-1:0]    col_bits;
  logic [COLS-1:0]              col_full;
  logic [COLS-1:0][ROW_W-1:0]   land_row;
  logic [COL_W-1:0]             rand_start;

  function automatic logic [ROW_W-1:0] landing_row(input logic [ROWS-1:0] bits);
    logic [ROW_W-1:0] r_sel;
    r_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!bits[r]) r_sel = ROW_W'(r);
    end
    return r_sel;
  endfunction

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    for (genvar ri = 0; ri < ROWS; ri++) begin : g_row
      assign col_bits[gi][ri] = board_reg[ri][gi];
    end
    assign col_full[gi] = board_reg[0][gi];
    assign land_row[gi] = landing_row(col_bits[gi]);
  end

  assign rand_start = COL_W'(lfsr_value % 16'(COLS));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      board_reg     <= '0;
      cur_col_reg   <= '0;
      probe_cnt_reg <= '0;
      res_col_reg   <= '0;
      res_row_reg   <= '0;
      res_none_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      no_move_reg   <= 1'b0;
      col_out_reg   <= '0;
      row_out_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            board_reg     <= board_in;
            cur_col_reg   <= mode ? '0 : rand_start;
            probe_cnt_reg <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!col_full[cur_col_reg]) begin
            res_col_reg  <= cur_col_reg;
            res_row_reg  <= land_row[cur_col_reg];
            res_none_reg <= 1'b0;
            state_reg    <= ST_DONE;
          end else if (probe_cnt_reg == COL_W'(COLS - 1)) begin
            res_col_reg  <= '0;
            res_row_reg  <= '0;
            res_none_reg <= 1'b1;
            state_reg    <= ST_DONE;
          end else begin
            probe_cnt_reg <= probe_cnt_reg + 1'b1;
            cur_col_reg   <= (cur_col_reg == COL_W'(COLS - 1)) ? '0 : cur_col_reg + 1'b1;
          end
        end
        ST_DONE: begin
          // Results reach the ports together with done so they stay stable between pulses.
          done_reg    <= 1'b1;
          busy_reg    <= 1'b0;
          col_out_reg <= res_col_reg;
          row_out_reg <= res_row_reg;
          no_move_reg <= res_none_reg;
          state_reg   <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign no_move = no_move_reg;
  assign col_out = col_out_reg;
  assign row_out = row_out_reg;

endmodule

// File: tb/tb_random_move_selector.sv
// Directed bench for random_move_selector on the default 6x7 board.
// Scenario tasks run in sequence; each compares DUT outputs with hand-derived values.
module tb_random_move_selector;

  logic             clk;
  logic             rst;
  logic             start;
  logic             mode;
  logic [5:0][6:0]  board_in;
  logic             busy;
  logic             done;
  logic             no_move;
  logic [2:0]       col_out;
  logic [2:0]       row_out;

  int n_cmp;
  int n_bad;

  random_move_selector dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .board_in (board_in),
    .busy     (busy),
    .done     (done),
    .no_move  (no_move),
    .col_out  (col_out),
    .row_out  (row_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0][6:0] full_cols(input logic [6:0] mask);
    logic [5:0][6:0] b;
    for (int r = 0; r < 6; r++) b[r] = mask;
    return b;
  endfunction

  // Issue one request; lat = number of edges after the accept edge until done is seen (-1 on timeout).
  task automatic do_req(input logic m, output int lat);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    board_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (no_move !== 1'b0) begin n_bad++; $display("FAIL reset_no_move got=%b want=0", no_move); end
    n_cmp++; if (col_out !== 3'd0) begin n_bad++; $display("FAIL reset_col got=%0d want=0", col_out); end
    n_cmp++; if (row_out !== 3'd0) begin n_bad++; $display("FAIL reset_row got=%0d want=0", row_out); end
    @(negedge clk);
    rst = 1'b1;
    $display("reset released");
  endtask

  task automatic test_empty_mode1();
    int lat;
    board_in = '0;
    @(negedge clk);
    mode = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_accept got=%b want=1", busy); end
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin lat = i; break; end
    end
    $display("empty mode1: lat=%0d col=%0d row=%0d no_move=%b", lat, col_out, row_out, no_move);
    n_cmp++; if (lat != 2)          begin n_bad++; $display("FAIL empty_latency got=%0d want=2", lat); end
    n_cmp++; if (col_out !== 3'd0)  begin n_bad++; $display("FAIL empty_col got=%0d want=0", col_out); end
    n_cmp++; if (row_out !== 3'd5)  begin n_bad++; $display("FAIL empty_row got=%0d want=5", row_out); end
    n_cmp++; if (no_move !== 1'b0)  begin n_bad++; $display("FAIL empty_no_move got=%b want=0", no_move); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL busy_at_done got=%b want=0", busy); end
    @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL done_one_cycle got=%b want=0", done); end
  endtask

  task automatic test_avoid_full();
    int lat;
    bit seen [7];
    int bad_col;
    int bad_row;
    int bad_lat;
    for (int c = 0; c < 7; c++) seen[c] = 1'b0;
    bad_col = 0;
    bad_row = 0;
    bad_lat = 0;
    board_in = full_cols(7'b0001001);
    for (int n = 0; n < 200; n++) begin
      do_req(1'b0, lat);
      $display("req %0d: lat=%0d col=%0d row=%0d", n, lat, col_out, row_out);
      if (lat < 2 || lat > 3) bad_lat++;
      if (col_out == 3'd0 || col_out == 3'd3 || col_out > 3'd6) bad_col++;
      else seen[col_out] = 1'b1;
      if (row_out !== 3'd5 || no_move !== 1'b0) bad_row++;
      // Vary the idle gap so requests sample the LFSR at different phases.
      repeat (n % 3) @(posedge clk);
    end
    n_cmp++; if (bad_col != 0) begin n_bad++; $display("FAIL avoid_full_col got=%0d want=0 bad picks", bad_col); end
    n_cmp++; if (bad_row != 0) begin n_bad++; $display("FAIL avoid_full_row got=%0d want=0 bad rows", bad_row); end
    n_cmp++; if (bad_lat != 0) begin n_bad++; $display("FAIL avoid_full_lat got=%0d want=0 bad latencies", bad_lat); end
    for (int c = 0; c < 7; c++) begin
      if (c != 0 && c != 3) begin
        n_cmp++;
        if (!seen[c]) begin n_bad++; $display("FAIL coverage_col%0d got=unseen want=seen", c); end
      end
    end
  endtask

  task automatic test_last_column();
    int lat;
    board_in = full_cols(7'b0111111);
    for (int n = 0; n < 4; n++) begin
      do_req(1'b0, lat);
      $display("last column: lat=%0d col=%0d row=%0d", lat, col_out, row_out);
      n_cmp++; if (col_out !== 3'd6) begin n_bad++; $display("FAIL last_col got=%0d want=6", col_out); end
      n_cmp++; if (row_out !== 3'd5) begin n_bad++; $display("FAIL last_row got=%0d want=5", row_out); end
      n_cmp++; if (lat < 2 || lat > 8) begin n_bad++; $display("FAIL last_latency got=%0d want=2..8", lat); end
      repeat (n) @(posedge clk);
    end
  endtask

  task automatic test_full_board();
    int lat;
    board_in = full_cols(7'b1111111);
    do_req(1'b0, lat);
    $display("full board: lat=%0d col=%0d row=%0d no_move=%b", lat, col_out, row_out, no_move);
    n_cmp++; if (lat != 8)          begin n_bad++; $display("FAIL full_latency got=%0d want=8", lat); end
    n_cmp++; if (no_move !== 1'b1)  begin n_bad++; $display("FAIL full_no_move got=%b want=1", no_move); end
    n_cmp++; if (col_out !== 3'd0)  begin n_bad++; $display("FAIL full_col got=%0d want=0", col_out); end
    n_cmp++; if (row_out !== 3'd0)  begin n_bad++; $display("FAIL full_row got=%0d want=0", row_out); end
  endtask

  task automatic test_partial_column();
    int lat;
    board_in = full_cols(7'b1111011);
    board_in[2][2] = 1'b1;
    board_in[3][2] = 1'b1;
    board_in[4][2] = 1'b1;
    board_in[5][2] = 1'b1;
    do_req(1'b1, lat);
    $display("partial column: lat=%0d col=%0d row=%0d no_move=%b", lat, col_out, row_out, no_move);
    n_cmp++; if (col_out !== 3'd2) begin n_bad++; $display("FAIL partial_col got=%0d want=2", col_out); end
    n_cmp++; if (row_out !== 3'd1) begin n_bad++; $display("FAIL partial_row got=%0d want=1", row_out); end
    n_cmp++; if (lat != 4)         begin n_bad++; $display("FAIL partial_latency got=%0d want=4", lat); end
    n_cmp++; if (no_move !== 1'b0) begin n_bad++; $display("FAIL partial_no_move got=%b want=0", no_move); end
  endtask

  // Full board captured, then start held and board emptied while busy: result must not change.
  task automatic test_ignore_while_busy();
    int lat;
    int extra;
    board_in = full_cols(7'b1111111);
    @(negedge clk);
    mode = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    board_in = '0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      if (i >= 2 && i <= 4) start = 1'b1;
      else start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin lat = i; break; end
    end
    start = 1'b0;
    $display("ignore busy: lat=%0d no_move=%b col=%0d", lat, no_move, col_out);
    n_cmp++; if (lat != 8)         begin n_bad++; $display("FAIL busy_latency got=%0d want=8", lat); end
    n_cmp++; if (no_move !== 1'b1) begin n_bad++; $display("FAIL busy_board_change got=%b want=1", no_move); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    n_cmp++; if (extra != 0)       begin n_bad++; $display("FAIL busy_extra_done got=%0d want=0", extra); end
    n_cmp++; if (no_move !== 1'b1) begin n_bad++; $display("FAIL hold_no_move got=%b want=1", no_move); end
  endtask

  task automatic test_midscan_reset();
    int dones;
    int lat;
    board_in = full_cols(7'b1111111);
    @(negedge clk);
    mode = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midscan_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midscan_done got=%b want=0", done); end
    n_cmp++; if (no_move !== 1'b0) begin n_bad++; $display("FAIL midscan_no_move got=%b want=0", no_move); end
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    $display("midscan reset: dones after abort=%0d", dones);
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL midscan_no_done got=%0d want=0", dones); end
    board_in = '0;
    do_req(1'b1, lat);
    $display("after abort: lat=%0d col=%0d row=%0d", lat, col_out, row_out);
    n_cmp++; if (lat != 2 || row_out !== 3'd5) begin
      n_bad++; $display("FAIL recover_after_abort got=lat%0d/row%0d want=lat2/row5", lat, row_out);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    board_in = '0;
    test_reset();
    test_empty_mode1();
    test_avoid_full();
    test_last_column();
    test_full_board();
    test_partial_column();
    test_ignore_while_busy();
    test_midscan_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
